// File: rtl/ysyx_22050133_divider.sv
// Multi-cycle radix-2 restoring divider for the RV64M EX stage.
// Produces quotient and remainder together and pulses out_valid for one cycle.
// Serves DIV/DIVU/REM/REMU and the 32-bit W variants.
module ysyx_22050133_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned HALF  = XLEN / 2;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    // Most negative value of each operand size, after sizing to XLEN bits.
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    // FSM and datapath state
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  dvd_q,     dvd_d;
    logic [XLEN-1:0]  rem_q,     rem_d;
    logic [XLEN-1:0]  quo_q,     quo_d;
    logic [XLEN-1:0]  dsr_q,     dsr_d;
    logic             qneg_q,    qneg_d;
    logic             rneg_q,    rneg_d;
    logic             w_q,       w_d;
    logic             ready_d;
    logic             valid_d;
    logic [XLEN-1:0]  quotient_d;
    logic [XLEN-1:0]  remainder_d;

    // Operand sizing, sign detection and special-case detection
    logic [XLEN-1:0] a_sz;
    logic [XLEN-1:0] b_sz;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            sgn_ovf;

    // Iteration step and final correction
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic            q_bit;
    logic [XLEN-1:0] q_sgn;
    logic [XLEN-1:0] r_sgn;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // W ops use the low half, sign- or zero-extended by signedness
    assign a_sz = !divw ? dividend :
                  div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]} :
                               {{HALF{1'b0}}, dividend[HALF-1:0]};
    assign b_sz = !divw ? divisor :
                  div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]} :
                               {{HALF{1'b0}}, divisor[HALF-1:0]};

    // Magnitudes for the unsigned iteration
    assign sa    = div_signed & a_sz[XLEN-1];
    assign sb    = div_signed & b_sz[XLEN-1];
    assign a_mag = sa ? -a_sz : a_sz;
    assign b_mag = sb ? -b_sz : b_sz;

    // Cases resolved without iterating
    assign div_zero = (b_sz == '0);
    assign sgn_ovf  = div_signed && (b_sz == '1) &&
                      (a_sz == (divw ? MIN_W : MIN_D));

    // One restoring step: shift in next dividend MSB, trial-subtract divisor
    assign r_sh  = {rem_q, dvd_q[XLEN-1]};
    assign diff  = r_sh - {1'b0, dsr_q};
    assign q_bit = ~diff[XLEN];

    // Sign correction, then W results are sign-extended from bit 31
    assign q_sgn = qneg_q ? -quo_q : quo_q;
    assign r_sgn = rneg_q ? -rem_q : rem_q;
    assign q_fix = w_q ? {{HALF{q_sgn[HALF-1]}}, q_sgn[HALF-1:0]} : q_sgn;
    assign r_fix = w_q ? {{HALF{r_sgn[HALF-1]}}, r_sgn[HALF-1:0]} : r_sgn;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        w_d         = w_q;
        valid_d     = 1'b0;
        quotient_d  = quotient;
        remainder_d = remainder;

        case (state_q)
            S_IDLE: begin
                if (div_ready && div_valid && !flush) begin
                    w_d = divw;
                    if (div_zero) begin
                        // Result parked in the iteration registers; FIX registers it
                        quo_d   = '1;
                        rem_d   = a_sz;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIX;
                    end else if (sgn_ovf) begin
                        quo_d   = a_sz;
                        rem_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIX;
                    end else begin
                        // W dividend is left-aligned so its MSB is shifted in first
                        dvd_d   = divw ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                        dsr_d   = b_mag;
                        rem_d   = '0;
                        quo_d   = '0;
                        qneg_d  = sa ^ sb;
                        rneg_d  = sa;
                        cnt_d   = divw ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
                        state_d = S_DIV;
                    end
                end
            end

            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = q_bit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], q_bit};
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    valid_d     = 1'b1;
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            w_q       <= 1'b0;
            div_ready <= 1'b0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            w_q       <= w_d;
            div_ready <= ready_d;
            out_valid <= valid_d;
            quotient  <= quotient_d;
            remainder <= remainder_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_divider.sv
// Self-checking bench for ysyx_22050133_divider: scoreboard of expected
// results, a negedge monitor that checks the out_valid timing every cycle.
module tb_ysyx_22050133_divider;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        div_valid;
    logic        divw;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          total;
    int          bad;
    int          cyc;
    logic        mon_en;
    exp_t        sbq[$];
    logic [63:0] last_q;
    logic [63:0] last_r;
    exp_t        mon_e;
    logic        mon_exp;

    ysyx_22050133_divider dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .div_valid  (div_valid),
        .divw       (divw),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] q, input logic [63:0] r, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference model with RISC-V M semantics
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic w, input logic s);
        exp_t e;
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            e.lat = 33;
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; e.lat = 1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; e.lat = 1;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            e.q = {{32{q32[31]}}, q32};
            e.r = {{32{r32[31]}}, r32};
        end else begin
            e.lat = 65;
            if (b == 64'd0) begin
                q64 = '1; r64 = a; e.lat = 1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = '0; e.lat = 1;
            end else if (s) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            e.q = q64;
            e.r = r64;
        end
        e.acc = 0;
        return e;
    endfunction

    // Wait for div_ready, present one operation, push its expectation
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic w, input logic s, input exp_t e);
        int n;
        exp_t ee;
        n = 0;
        @(negedge clk);
        while (!div_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!div_ready) chk("ready_timeout", 64'(div_ready), 64'd1);
        dividend   = a;
        divisor    = b;
        divw       = w;
        div_signed = s;
        div_valid  = 1'b1;
        ee         = e;
        ee.acc     = cyc + 1;
        sbq.push_back(ee);
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    // Accept an operation, then flush it at edge E(k+1)
    task automatic flush_op(input logic [63:0] a, input logic [63:0] b,
                            input logic w, input logic s, input int k);
        exp_t dummy;
        do_op(a, b, w, s, model(a, b, w, s));
        repeat (k) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        dummy = sbq.pop_back();
        chk("flush_ready", 64'(div_ready), 64'd1);
        chk("flush_hold_q", quotient, last_q);
        chk("flush_hold_r", remainder, last_r);
        repeat (70) @(posedge clk);
    endtask

    // Every cycle: out_valid must be high exactly at the expected completion
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp = (sbq.size() > 0) && (cyc == sbq[0].acc + sbq[0].lat);
            chk("out_valid", 64'(out_valid), 64'(mon_exp));
            if (mon_exp) begin
                mon_e = sbq.pop_front();
                chk("quotient", quotient, mon_e.q);
                chk("remainder", remainder, mon_e.r);
                last_q = mon_e.q;
                last_r = mon_e.r;
            end
        end
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rw, rs;
        total = 0; bad = 0; cyc = 0; mon_en = 1'b0;
        last_q = '0; last_r = '0;
        rst = 1'b0; flush = 1'b0; div_valid = 1'b0;
        divw = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;

        #1;
        chk("rst_ready", 64'(div_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready0", 64'(div_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rel_ready1", 64'(div_ready), 64'd1);
        mon_en = 1'b1;

        // Directed cases with hand-computed results
        do_op(64'd100, 64'd7, 1'b0, 1'b0, mk(64'd14, 64'd2, 65));
        wait_idle(200);
        do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1,
              mk(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65));
        do_op(64'd5, 64'd0, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1));
        do_op(64'h1234, 64'd0, 1'b1, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1));
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
              mk(64'h8000_0000_0000_0000, 64'd0, 1));
        do_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
              mk(64'hFFFF_FFFF_8000_0000, 64'd0, 1));
        do_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
              mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33));
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              mk(64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 65));
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
              mk(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 65));
        wait_idle(400);

        // Flush mid-iteration, flush in the FIX cycle, flush while idle
        flush_op(64'd1000, 64'd3, 1'b0, 1'b0, 9);
        flush_op(64'd999, 64'd5, 1'b0, 1'b1, 64);
        @(negedge clk);
        dividend = 64'd77; divisor = 64'd7; divw = 1'b0; div_signed = 1'b0;
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", 64'(div_ready), 64'd1);
        repeat (70) @(posedge clk);

        // Randomised back-to-back mix, checked against the model
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = 64'($urandom_range(1, 20));
                1: rb = 64'($urandom);
                2: rb = {$urandom, $urandom};
                3: rb = -64'($urandom_range(1, 20));
                default: rb = 64'd0;
            endcase
            rw = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rw, rs, model(ra, rb, rw, rs));
        end
        wait_idle(3000);

        // Asynchronous reset in the middle of an operation
        do_op(64'd123456789, 64'd1000, 1'b0, 1'b0, model(64'd123456789, 64'd1000, 1'b0, 1'b0));
        repeat (20) @(posedge clk);
        mon_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ready", 64'(div_ready), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_q", quotient, 64'd0);
        chk("arst_r", remainder, 64'd0);
        sbq.delete();
        last_q = '0;
        last_r = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arel_ready0", 64'(div_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("arel_ready1", 64'(div_ready), 64'd1);
        mon_en = 1'b1;

        do_op(64'd1000, 64'd3, 1'b0, 1'b0, mk(64'd333, 64'd1, 65));
        do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1,
              mk(64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33));
        wait_idle(300);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
